// File: rtl/scan_pkg.sv
// Shared definitions for the scanned 7-segment display blocks: scan phase
// encoding, the all-segments-off code and the active-low hex glyph table.
package scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is off in every entry.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble + decimal point to active-low segment decoder.
module hex7seg_dec
  import scan_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg_n
);

  always_comb begin
    seg_n    = SEG_HEX[nib];
    seg_n[7] = ~dp;
  end

endmodule

// File: rtl/scan_mux_display.sv
// Time-multiplexed N-digit 7-segment scanner with per-slot dead time,
// blanking and frame strobe. Define SCAN_BLINK_EN to add blink_mask support.
module scan_mux_display
  import scan_pkg::*;
#(
  parameter int N_DIG    = 8,
  parameter int DIV      = 1000,
  parameter int DEAD_CYC = 2
`ifdef SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic               clks,
  input  logic               rst_n,
  input  logic               en,
  input  logic [4*N_DIG-1:0] digits_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blank_mask,
`ifdef SCAN_BLINK_EN
  input  logic [N_DIG-1:0]   blink_mask,
`endif
  output logic [N_DIG-1:0]   sel_n,
  output logic [7:0]         seg_n,
  output logic               frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  scan_state_t   state, state_nxt;
  logic          capture;
  logic          blank_eff;

  logic [3:0]    lat_nib;
  logic          lat_dp;
  logic          lat_blank;
  logic [IW-1:0] lat_idx;
  logic [7:0]    dec_seg;

  assign frame_done = (cnt == CNT_LAST) && (idx == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clks or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!en) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clks or negedge rst_n) begin
    if (!rst_n) state <= BLANK;
    else        state <= state_nxt;
  end

  // NOTE: defaults first so no path through this block infers a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (!en) begin
      state_nxt = BLANK;
    end else if (cnt == CNT_DEAD) begin
      state_nxt = DRIVE;
      capture   = 1'b1;
    end else if (cnt == '0) begin
      state_nxt = BLANK;
    end
  end

`ifdef SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  always_ff @(posedge clks or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!en) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_done) begin
      if (frame_cnt == FRM_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blank_eff = blank_mask[idx] | (blink_phase & blink_mask[idx]);
`else
  assign blank_eff = blank_mask[idx];
`endif

  // Slot latch: frozen for the whole slot so mid-slot input changes cannot tear.
  always_ff @(posedge clks or negedge rst_n) begin
    if (!rst_n) begin
      lat_nib   <= '0;
      lat_dp    <= 1'b0;
      lat_blank <= 1'b1;
      lat_idx   <= '0;
    end else if (capture) begin
      lat_nib   <= digits_in[{idx, 2'b00} +: 4];
      lat_dp    <= dp_in[idx];
      lat_blank <= blank_eff;
      lat_idx   <= idx;
    end
  end

  hex7seg_dec u_dec (
    .nib   (lat_nib),
    .dp    (lat_dp),
    .seg_n (dec_seg)
  );

  // Blanked digits keep their select asserted so every digit gets equal duty.
  always_ff @(posedge clks or negedge rst_n) begin
    if (!rst_n) begin
      sel_n <= '1;
      seg_n <= SEG_OFF;
    end else if (!en || state == BLANK) begin
      sel_n <= '1;
      seg_n <= SEG_OFF;
    end else begin
      sel_n <= ~(N_DIG'(1) << lat_idx);
      seg_n <= lat_blank ? SEG_OFF : dec_seg;
    end
  end

endmodule

// File: tb/tb_scan_mux_display.sv
// Self-checking bench for scan_mux_display (N_DIG=4, DIV=4, DEAD_CYC=1);
// exercises the blink path too when SCAN_BLINK_EN is defined.
module tb_scan_mux_display;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int DC = 1;
  localparam int BF = 2;
`ifdef SCAN_BLINK_EN
  localparam bit HAS_BLINK = 1'b1;
`else
  localparam bit HAS_BLINK = 1'b0;
`endif

  logic           clks = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [N-1:0]   blank_mask = '0;
  logic [N-1:0]   blink_mask = '0;
  logic [N-1:0]   sel_n;
  logic [7:0]     seg_n;
  logic           frame_done;

  int n_checks = 0;
  int n_fail = 0;
  int ke = 0;                 // enabled clock edges since scanning (re)started
  logic [3:0] m_nib = '0;     // model's view of the data shown in the current slot
  logic       m_dp = 1'b0;
  logic       m_blank = 1'b1;

  scan_mux_display #(
    .N_DIG(N), .DIV(D), .DEAD_CYC(DC)
`ifdef SCAN_BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) dut (
    .clks       (clks),
    .rst_n      (rst_n),
    .en         (en),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
`ifdef SCAN_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .sel_n      (sel_n),
    .seg_n      (seg_n),
    .frame_done (frame_done)
  );

  always #5 clks = ~clks;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][7:0] seg;   // expected seg_n per slot, index = slot
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  // One clock. Slot s samples its inputs on edge s*D+DC; that edge's index is ke.
  task automatic step();
    if (en && ((ke % D) == DC)) begin
      int  s;
      int  f;
      bit  ph;
      s = (ke / D) % N;
      f = ke / (D * N);
      ph = HAS_BLINK && (((f / BF) % 2) == 1);
      m_nib   = digits_in[4*s +: 4];
      m_dp    = dp_in[s];
      m_blank = blank_mask[s] | (ph & blink_mask[s]);
    end
    @(posedge clks);
    #1;
    ke = en ? ke + 1 : 0;
  endtask

  // Outputs after edge e show slot (e-1)/D, dark for its first DC clocks.
  task automatic model_check(input string tag);
    int         e;
    int         s;
    logic [N-1:0] es;
    logic [7:0] eg;
    logic [7:0] g;
    logic       ef;
    e  = ke - 1;
    es = '1;
    eg = 8'hFF;
    ef = 1'b0;
    if (ke > 0) begin
      ef = (((e + 2) % (D * N)) == 0);
      if (e > 0 && ((e - 1) % D) >= DC) begin
        s  = ((e - 1) / D) % N;
        es = ~(N'(1) << s);
        g  = glyph(m_nib);
        eg = m_blank ? 8'hFF : {~m_dp, g[6:0]};
      end
    end
    check({tag, " sel_n"}, 8'(sel_n), 8'(es));
    check({tag, " seg_n"}, seg_n, eg);
    check({tag, " frame_done"}, 8'(frame_done), 8'(ef));
  endtask

  initial begin
    int           fd_cnt;
    int           fd_first;
    logic [N-1:0] exp_sel;

    vecs[0] = '{16'h3210, 4'b0000, 4'b0000, {8'hB0, 8'hA4, 8'hF9, 8'hC0}};
    vecs[1] = '{16'h3210, 4'b0001, 4'b0100, {8'hB0, 8'hFF, 8'hF9, 8'h40}};
    vecs[2] = '{16'hFEDC, 4'b1010, 4'b0000, {8'h0E, 8'h86, 8'h21, 8'hC6}};
    vecs[3] = '{16'h9876, 4'b0000, 4'b1111, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[4] = '{16'hBA54, 4'b0100, 4'b0000, {8'h83, 8'h08, 8'h92, 8'h99}};

    // Reset and idle
    repeat (2) @(posedge clks);
    #1;
    check("reset sel_n", 8'(sel_n), 8'h0F);
    check("reset seg_n", seg_n, 8'hFF);
    check("reset frame_done", 8'(frame_done), 8'h00);
    @(negedge clks);
    rst_n = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (frame_done) fd_cnt++;
    end
    check("idle frame_done pulses", 8'(fd_cnt), 8'h00);
    check("idle sel_n", 8'(sel_n), 8'h0F);
    check("idle seg_n", seg_n, 8'hFF);

    // Table-driven frames: every clock of one full frame
    for (int v = 0; v < 5; v++) begin
      en = 1'b0;
      step();
      digits_in  = vecs[v].digits;
      dp_in      = vecs[v].dp;
      blank_mask = vecs[v].blank;
      en = 1'b1;
      for (int c = 0; c <= D * N; c++) begin
        int e;
        int s;
        step();
        e = ke - 1;
        if (e > 0 && ((e - 1) % D) >= DC) begin
          s = ((e - 1) / D) % N;
          exp_sel = ~(N'(1) << s);
          check($sformatf("vec%0d e%0d sel_n", v, e), 8'(sel_n), 8'(exp_sel));
          check($sformatf("vec%0d e%0d seg_n", v, e), seg_n, vecs[v].seg[s]);
        end else begin
          check($sformatf("vec%0d e%0d dead sel_n", v, e), 8'(sel_n), 8'h0F);
          check($sformatf("vec%0d e%0d dead seg_n", v, e), seg_n, 8'hFF);
        end
      end
    end

    // frame_done period: pulses after edges 14, 30, 46
    en = 1'b0;
    step();
    blank_mask = '0;
    dp_in = '0;
    en = 1'b1;
    fd_cnt = 0;
    fd_first = -1;
    for (int i = 0; i < 48; i++) begin
      step();
      if (frame_done) begin
        if (fd_first < 0) fd_first = ke - 1;
        fd_cnt++;
      end
    end
    check("frame_done count", 8'(fd_cnt), 8'd3);
    check("frame_done first edge", 8'(fd_first), 8'd14);

    // Mid-slot tearing: change data while slot 1 is driving
    en = 1'b0;
    step();
    digits_in = 16'h0000;
    en = 1'b1;
    repeat (7) step();
    digits_in = 16'hFFFF;
    repeat (2) step();
    check("tear slot1 sel_n", 8'(sel_n), 8'h0D);
    check("tear slot1 seg_n", seg_n, 8'hC0);
    repeat (2) step();
    check("tear slot2 sel_n", 8'(sel_n), 8'h0B);
    check("tear slot2 seg_n", seg_n, 8'h8E);

    // en dropped during slot 2, then restart with a dead cycle
    en = 1'b0;
    step();
    check("en-off sel_n", 8'(sel_n), 8'h0F);
    check("en-off seg_n", seg_n, 8'hFF);
    check("en-off frame_done", 8'(frame_done), 8'h00);
    en = 1'b1;
    step();
    check("restart e0 sel_n", 8'(sel_n), 8'h0F);
    step();
    check("restart dead sel_n", 8'(sel_n), 8'h0F);
    check("restart dead seg_n", seg_n, 8'hFF);
    step();
    check("restart slot0 sel_n", 8'(sel_n), 8'h0E);
    check("restart slot0 seg_n", seg_n, 8'h8E);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("async rst sel_n", 8'(sel_n), 8'h0F);
    check("async rst seg_n", seg_n, 8'hFF);
    @(negedge clks);
    rst_n = 1'b1;
    ke = 0;

`ifdef SCAN_BLINK_EN
    // Blink: digit 0 dark in frames 2-3, lit in 0-1 and 4-5
    en = 1'b0;
    step();
    digits_in  = 16'h0000;
    blink_mask = 4'b0001;
    en = 1'b1;
    for (int i = 0; i <= 6 * D * N; i++) begin
      int e;
      step();
      e = ke - 1;
      if ((e % (D * N)) == 4 && e >= 4) begin
        check($sformatf("blink frame%0d seg_n", e / (D * N)), seg_n,
              (((e / (D * N)) / BF) % 2 == 1) ? 8'hFF : 8'hC0);
      end
    end
    blink_mask = '0;
`endif

    // Randomized stimulus against the reference model
    en = 1'b0;
    step();
    en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(5) == 0) digits_in = 16'($urandom);
      if ($urandom_range(5) == 0) dp_in = 4'($urandom);
      if ($urandom_range(9) == 0) blank_mask = ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(9) == 0) blink_mask = 4'($urandom);
      if (en && $urandom_range(79) == 0) en = 1'b0;
      else if (!en && $urandom_range(2) == 0) en = 1'b1;
      step();
      model_check($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
